// File: rtl/line_buf_pkg.sv
// Shared sizing constants for the video line buffer.
package line_buf_pkg;

  localparam int LB_ADDR_WIDTH = 11;
  localparam int LB_DATA_WIDTH = 16;
  localparam int LB_DEPTH      = 2048;

  // Number of words addressable with an address of the given width.
  function automatic int lb_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/line_buf_sdpram_if.sv
// Producer/consumer bus of the line buffer: one write port and one read port.
interface line_buf_sdpram_if
  import line_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // The pixel producer/consumer side.
  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  // The RAM side.
  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/line_buf_rd_pipe.sv
// Read-side register stage(s): one stage for 1-cycle latency, or two when
// OUTPUT_REG is set. Both stages clear asynchronously on rd_rst.
module line_buf_rd_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] stage1_reg;

  // Capture the addressed word on every read clock; no read enable.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      stage1_reg <= '0;
    end else begin
      stage1_reg <= rd_word;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] stage2_reg;

      // Optional second stage to ease timing on the consumer side.
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
          stage2_reg <= '0;
        end else begin
          stage2_reg <= stage1_reg;
        end
      end

      assign rd_data = stage2_reg;
    end else begin : g_no_out_reg
      assign rd_data = stage1_reg;
    end
  endgenerate

endmodule

// File: rtl/line_buf_sdpram.sv
// Simple dual-port line buffer: producer writes a video line on wr_clk,
// consumer reads it back on rd_clk. Storage is never cleared by reset.
module line_buf_sdpram
  import line_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int OUTPUT_REG = 0
) (
  input  logic        wr_clk,
  input  logic        tb_wr_rst,
  input  logic        rd_clk,
  input  logic        rd_rst,
  line_buf_sdpram_if.slave bus
);

  localparam int DEPTH = lb_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_go;
  logic [DATA_WIDTH-1:0] rd_word;

  // Reset blocks writes as soon as it is asserted; it is sampled again at
  // each wr_clk edge, so the first edge after release may write.
  assign wr_go = bus.wr_en & ~tb_wr_rst;

  // Write port; the array itself carries no reset so it maps onto RAM.
  always_ff @(posedge wr_clk) begin
    if (wr_go) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // The word is sampled by the read pipeline on rd_clk. A same-edge write
  // lands via non-blocking update, so a colliding read returns old data.
  assign rd_word = mem[bus.rd_addr];

  line_buf_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_rd_pipe (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .rd_word (rd_word),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_line_buf_sdpram.sv
// Directed bench for the line buffer: two instances (1- and 2-cycle read
// latency) driven with identical stimulus, checked from expectation queues.
module tb_line_buf_sdpram;
  import line_buf_pkg::*;

  typedef struct {
    bit          chk;
    logic [15:0] val;
    string       tag;
  } exp_t;

  logic clk;
  logic wr_rst;
  logic rd_rst;

  int checks   = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  exp_t q0[$];
  exp_t q1[$];

  line_buf_sdpram_if #(.ADDR_WIDTH(LB_ADDR_WIDTH), .DATA_WIDTH(LB_DATA_WIDTH)) bus0 ();
  line_buf_sdpram_if #(.ADDR_WIDTH(LB_ADDR_WIDTH), .DATA_WIDTH(LB_DATA_WIDTH)) bus1 ();

  line_buf_sdpram #(
    .ADDR_WIDTH (LB_ADDR_WIDTH),
    .DATA_WIDTH (LB_DATA_WIDTH),
    .OUTPUT_REG (0)
  ) dut0 (
    .wr_clk    (clk),
    .tb_wr_rst (wr_rst),
    .rd_clk    (clk),
    .rd_rst    (rd_rst),
    .bus       (bus0)
  );

  line_buf_sdpram #(
    .ADDR_WIDTH (LB_ADDR_WIDTH),
    .DATA_WIDTH (LB_DATA_WIDTH),
    .OUTPUT_REG (1)
  ) dut1 (
    .wr_clk    (clk),
    .tb_wr_rst (wr_rst),
    .rd_clk    (clk),
    .rd_rst    (rd_rst),
    .bus       (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [10:0] wa, input logic [15:0] wd,
                       input logic [10:0] ra);
    bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.rd_addr = ra;
    bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd; bus1.rd_addr = ra;
  endtask

  // One clock: queue the expectation for the current rd_addr, then compare
  // the 1-cycle instance now and the 2-cycle instance one step later.
  task automatic step(input bit chk, input logic [15:0] exp, input string tag);
    exp_t e;
    if (rd_rst) begin
      @(posedge clk); #1;
      check(bus0.rd_data, 16'h0000, {tag, "_rst_r0"});
      check(bus1.rd_data, 16'h0000, {tag, "_rst_r1"});
    end else begin
      q0.push_back('{chk, exp, tag});
      q1.push_back('{chk, exp, tag});
      @(posedge clk); #1;
      e = q0.pop_front();
      if (e.chk) check(bus0.rd_data, e.val, {e.tag, "_lat1"});
      if (q1.size() > 1) begin
        e = q1.pop_front();
        if (e.chk) check(bus1.rd_data, e.val, {e.tag, "_lat2"});
      end
    end
  endtask

  // After rd_rst release the 2-cycle instance first shows its cleared stage 1.
  task automatic release_rd();
    rd_rst = 1'b0;
    q0.delete();
    q1.delete();
    q1.push_back('{1'b1, 16'h0000, "stage1_cleared"});
  endtask

  initial begin
    wr_rst = 1'b1;
    rd_rst = 1'b1;
    drive(1'b0, 11'd0, 16'h0000, 11'd0);

    // Reset state: both read ports hold zero.
    repeat (3) step(1'b0, 16'h0000, "reset");
    #2;
    wr_rst = 1'b0;
    release_rd();

    // Fill the whole line with 0xFFFF - addr.
    for (int a = 0; a < 2048; a++) begin
      drive(1'b1, 11'(a), 16'hFFFF - 16'(a), 11'd0);
      step(1'b0, 16'h0000, "fill");
    end
    drive(1'b0, 11'd0, 16'h0000, 11'd0);
    step(1'b0, 16'h0000, "guard");

    // Back-to-back full-line read.
    for (int a = 0; a < 2048; a++) begin
      drive(1'b0, 11'd0, 16'h0000, 11'(a));
      step(1'b1, 16'hFFFF - 16'(a), $sformatf("sweep_%0d", a));
    end

    // Address wrap: top word then word 0 on consecutive cycles.
    drive(1'b1, 11'd2047, 16'h0001, 11'd100);
    step(1'b0, 16'h0000, "wrap_wr_hi");
    drive(1'b1, 11'd0, 16'h0002, 11'd100);
    step(1'b0, 16'h0000, "wrap_wr_lo");
    drive(1'b0, 11'd0, 16'h0000, 11'd100);
    step(1'b0, 16'h0000, "guard");
    drive(1'b0, 11'd0, 16'h0000, 11'd2047);
    step(1'b1, 16'h0001, "wrap_rd_hi");
    drive(1'b0, 11'd0, 16'h0000, 11'd0);
    step(1'b1, 16'h0002, "wrap_rd_lo");

    // Write attempted while the write side is held in reset.
    #2;
    wr_rst = 1'b1;
    drive(1'b1, 11'd5, 16'hDEAD, 11'd100);
    step(1'b0, 16'h0000, "blocked_wr");
    drive(1'b0, 11'd0, 16'h0000, 11'd100);
    step(1'b0, 16'h0000, "guard");
    #2;
    wr_rst = 1'b0;
    drive(1'b0, 11'd0, 16'h0000, 11'd5);
    step(1'b1, 16'hFFFA, "wr_blocked");

    // Writes resume once the reset is released.
    drive(1'b1, 11'd6, 16'h0606, 11'd100);
    step(1'b0, 16'h0000, "resume_wr");
    drive(1'b0, 11'd0, 16'h0000, 11'd100);
    step(1'b0, 16'h0000, "guard");
    drive(1'b0, 11'd0, 16'h0000, 11'd6);
    step(1'b1, 16'h0606, "wr_resumed");

    // Read reset in the middle of a read burst.
    for (int a = 100; a < 108; a++) begin
      drive(1'b0, 11'd0, 16'h0000, 11'(a));
      step(1'b1, 16'hFFFF - 16'(a), $sformatf("pre_rst_%0d", a));
    end
    #1;
    rd_rst = 1'b1;
    #1;
    check(bus0.rd_data, 16'h0000, "rd_rst_async_r0");
    check(bus1.rd_data, 16'h0000, "rd_rst_async_r1");
    drive(1'b0, 11'd0, 16'h0000, 11'd108);
    repeat (2) step(1'b0, 16'h0000, "rd_rst_hold");
    #2;
    release_rd();
    for (int a = 108; a < 116; a++) begin
      drive(1'b0, 11'd0, 16'h0000, 11'(a));
      step(1'b1, 16'hFFFF - 16'(a), $sformatf("post_rst_%0d", a));
    end

    // Same-edge collision at address 10 (read-first).
    drive(1'b1, 11'd10, 16'h1111, 11'd100);
    step(1'b0, 16'h0000, "coll_init");
    drive(1'b0, 11'd0, 16'h0000, 11'd100);
    step(1'b0, 16'h0000, "guard");
    drive(1'b1, 11'd10, 16'h2222, 11'd10);
    step(1'b1, 16'h1111, "coll_old");
    drive(1'b0, 11'd0, 16'h0000, 11'd10);
    step(1'b1, 16'h2222, "coll_new");

    // Drain the 2-cycle instance's last expectation.
    drive(1'b0, 11'd0, 16'h0000, 11'd0);
    step(1'b0, 16'h0000, "flush");
    step(1'b0, 16'h0000, "flush");

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/line_buf_sdpram.md
Name: line_buf_sdpram

Overview:
- Simple dual-port line buffer RAM, 2048 words x 16 bits by default.
- Independent write port (wr_clk) and read port (rd_clk); the clocks may be asynchronous to each other.
- Holds one video line: the pixel producer writes it and the consumer reads it back.
- Read data is registered, with 1-cycle latency by default; an optional extra output register is available.

Parameters:
- ADDR_WIDTH, 11: address width of both ports; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 16: word width of both ports.
- OUTPUT_REG, 0: 1 adds a second read pipeline register, giving 2-cycle latency.

Ports:
- wr_clk  in  1  write clock.
- tb_wr_rst  in  1  write-side reset.
- rd_clk  in  1  read clock.
- rd_rst  in  1  read-side reset, asynchronous, active-high.
- wr_en  in  1  write strobe, sampled on rising wr_clk.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_addr  in  ADDR_WIDTH  read address, sampled every rising rd_clk; there is no read enable.
- rd_data  out  DATA_WIDTH  registered read data.
- Interface rule: reset tb_wr_rst, asynchronous, active-high; clock wr_clk.

Behaviour:
- Storage: array of 2**ADDR_WIDTH words.
  - Contents are not cleared by either reset.
  - Contents are undefined (X) until written.
- Write:
  - On rising wr_clk with wr_en=1 and tb_wr_rst=0: mem[wr_addr] <= wr_data.
  - While tb_wr_rst=1, writes are blocked. Assertion is immediate; release takes effect at the next wr_clk edge.
  - wr_en=0: no change.
- Read, OUTPUT_REG=0:
  - On rising rd_clk: rd_data <= mem[rd_addr].
  - rd_addr applied before edge N gives its data on rd_data after edge N (1-cycle latency).
  - A new word is delivered every cycle; full throughput.
- Read, OUTPUT_REG=1:
  - Stage-1 register as above, then rd_data <= stage1 on the next edge (2-cycle latency).
- Reset values:
  - rd_rst=1 clears rd_data and the stage-1 register to 0 asynchronously.
  - The read port stays idle at 0 until the first rd_clk edge after release.
- Address wrap: addresses are exactly ADDR_WIDTH bits. 2**ADDR_WIDTH-1 followed by 0 is legal and needs no special handling.
- Same-address collision:
  - Same clock edge, same address on both ports: the read returns the old (pre-write) data (read-first).
  - With asynchronous clocks, a read of a word being written in the same window returns either old or new data. The writer must keep a one-cycle guard between the two.
- Reset mid-operation:
  - tb_wr_rst asserted mid-line drops the in-flight write; earlier words are kept.
  - rd_rst mid-read zeroes rd_data without altering memory.
- No full/empty flags: the caller owns the address sequencing.

Decomposition:
- Package line_buf_pkg: LB_ADDR_WIDTH=11, LB_DATA_WIDTH=16, LB_DEPTH=2048.
- One natural sub-module, line_buf_rd_pipe: the read register stage(s) with rd_rst and OUTPUT_REG selection.
- The memory array and write logic stay in the top module.

Test Plan:
- Full-line sweep, OUTPUT_REG=0:
  - Release both resets, then write addr a (0..2047) with data 16'hFFFF-a.
  - Read addr 0..2047 back-to-back: rd_data one cycle after each address equals 16'hFFFF-a; zero mismatches.
- Wrap: write 2047=16'h0001, then 0=16'h0002 on consecutive cycles. Reading 2047 then 0 gives 16'h0001, 16'h0002.
- Write blocked in reset: hold tb_wr_rst=1, pulse wr_en at addr 5 with 16'hDEAD. Reading addr 5 returns its prior value 16'hFFFA.
- Read reset: assert rd_rst mid-read. rd_data becomes 16'h0000 immediately, and memory still reads 16'hFFFF-a after release.
- Collision, rd_clk tied to wr_clk: addr 10 holds 16'h1111; write 16'h2222 at addr 10 while reading addr 10. The same-edge read gives 16'h1111, the next read 16'h2222.
- OUTPUT_REG=1: repeat the sweep; data appears 2 cycles after the address, all values match.
